mandel_pixel_scheduler: RTL and testbench

// Raster scheduler feeding vga_adapter: walks every pixel of the frame in raster order.
// For each pixel:
//  - issues the complex-plane coordinate to the Mandelbrot iteration engine (req/ack);
//  - waits for the iteration count;
//  - maps the count to a 3-bit colour;
//  - pulses plot for one cycle with x/y/colour.
// One frame per start pulse; done flags completion.

---
 rtl/mandel_pixel_scheduler_pkg.sv | 33 +++
 rtl/mandel_pixel_scheduler_if.sv | 31 +++
 rtl/mandel_pixel_scheduler_raster_counter.sv | 53 +++++
 rtl/mandel_pixel_scheduler.sv | 83 ++++++++
 tb/tb_mandel_pixel_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pixel_scheduler_pkg.sv
// Shared types and constants for the Mandelbrot pixel scheduler.
// Coordinates are signed Q4.28; the state enum covers the per-pixel
// request/wait/plot cycle. iter_to_colour() maps an iteration count to
// the 3-bit colour sent to the VGA adapter.
package mandel_pixel_scheduler_pkg;

  localparam int COORD_W  = 32;
  localparam int FRAC_W   = 28;
  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 255;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, PLOT, DONE} state_t;

  // -2.0 and +1.0 in Q4.28
  localparam coord_t X_START_Q = -32'sd536870912;
  localparam coord_t Y_START_Q =  32'sd268435456;

  // 3.0 / width in Q4.28, truncated toward zero
  function automatic coord_t step_for(input int width);
    return coord_t'((3 * (1 << FRAC_W)) / width);
  endfunction

  // Points inside the set draw black; zero low bits would also be black,
  // so they are pushed to white to keep escaped points visible.
  function automatic logic [2:0] iter_to_colour(input logic [ITER_W-1:0] iter);
    if (iter == ITER_W'(MAX_ITER)) return 3'b000;
    else if (iter[2:0] == 3'b000)  return 3'b111;
    else                           return iter[2:0];
  endfunction

endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// Bus between the pixel scheduler, the iteration engine and the VGA adapter.
//   eng_req/eng_cr/eng_ci  : coordinate request (req&ack same cycle = transfer)
//   eng_ack                : engine accepts request
//   eng_valid/eng_iter     : one-cycle result pulse with iteration count
//   x/y/colour/plot        : pixel write to the VGA adapter
// master = scheduler side, slave = engine/VGA side.
interface mandel_pixel_scheduler_if #(
  parameter int COORD_W = 32,
  parameter int ITER_W  = 8
);
  logic                      eng_req;
  logic signed [COORD_W-1:0] eng_cr;
  logic signed [COORD_W-1:0] eng_ci;
  logic                      eng_ack;
  logic                      eng_valid;
  logic [ITER_W-1:0]         eng_iter;
  logic [7:0]                x;
  logic [6:0]                y;
  logic [2:0]                colour;
  logic                      plot;

  modport master (
    output eng_req, eng_cr, eng_ci, x, y, colour, plot,
    input  eng_ack, eng_valid, eng_iter
  );

  modport slave (
    input  eng_req, eng_cr, eng_ci, x, y, colour, plot,
    output eng_ack, eng_valid, eng_iter
  );
endinterface

// File: rtl/mandel_pixel_scheduler_raster_counter.sv
// Raster position counter with complex-plane accumulators.
//   clock, resetn : clock and synchronous active-low reset
//   load          : restart at pixel (0,0) with cr/ci at the frame origin
//   advance       : step to the next pixel in raster order
//   x, y          : current pixel
//   cr, ci        : complex coordinate of the current pixel
//   last          : current pixel is the final one of the frame
module raster_counter
  import mandel_pixel_scheduler_pkg::*;
#(
  parameter int     WIDTH   = 160,
  parameter int     HEIGHT  = 120,
  parameter coord_t X_START = X_START_Q,
  parameter coord_t Y_START = Y_START_Q,
  parameter coord_t STEP    = step_for(160)
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] x,
  output logic [6:0] y,
  output coord_t     cr,
  output coord_t     ci,
  output logic       last
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  // cr/ci wrap naturally; the parameters are expected to keep the frame in range
  always_ff @(posedge clock) begin
    if (!resetn || load) begin
      x  <= '0;
      y  <= '0;
      cr <= X_START;
      ci <= Y_START;
    end else if (advance) begin
      if (x != X_LAST) begin
        x  <= x + 8'd1;
        cr <= cr + STEP;
      end else begin
        x  <= '0;
        cr <= X_START;
        y  <= y + 7'd1;
        ci <= ci - STEP;
      end
    end
  end

  assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Raster scheduler: walks every pixel of the frame, requests its iteration
// count from the Mandelbrot engine, maps it to a colour and strobes plot.
//   clock, resetn : clock and synchronous active-low reset
//   start         : begin a frame (honoured only in IDLE or DONE)
//   done          : high while the frame is complete
//   bus           : engine request/result handshake and VGA pixel write
module mandel_pixel_scheduler
  import mandel_pixel_scheduler_pkg::*;
#(
  parameter int     WIDTH   = 160,
  parameter int     HEIGHT  = 120,
  parameter coord_t X_START = X_START_Q,
  parameter coord_t Y_START = Y_START_Q,
  parameter coord_t STEP    = step_for(WIDTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     start,
  output logic                     done,
  mandel_pixel_scheduler_if.master bus
);

  state_t     state, state_n;
  logic       load, advance, last;
  logic [2:0] colour_p0;
  logic [7:0] x;
  logic [6:0] y;
  coord_t     cr, ci;

  raster_counter #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT),
    .X_START(X_START), .Y_START(Y_START), .STEP(STEP)
  ) u_raster (
    .clock(clock), .resetn(resetn), .load(load), .advance(advance),
    .x(x), .y(y), .cr(cr), .ci(ci), .last(last)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // Stage p0: colour captured with the engine result, presented during PLOT
  always_ff @(posedge clock) begin
    if (!resetn)                            colour_p0 <= 3'b000;
    else if (state == WAIT && bus.eng_valid) colour_p0 <= iter_to_colour(bus.eng_iter);
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        load    = 1'b1;
        state_n = REQ;
      end
      REQ:  if (bus.eng_ack)   state_n = WAIT;
      WAIT: if (bus.eng_valid) state_n = PLOT;
      PLOT: begin
        if (last) begin
          state_n = DONE;
        end else begin
          advance = 1'b1;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // x/y/cr/ci come straight from the counter, which only moves on load or
  // on leaving PLOT, so they hold steady from REQ through PLOT.
  assign bus.eng_req = (state == REQ);
  assign bus.eng_cr  = cr;
  assign bus.eng_ci  = ci;
  assign bus.plot    = (state == PLOT);
  assign bus.x       = x;
  assign bus.y       = y;
  assign bus.colour  = colour_p0;
  assign done        = (state == DONE);

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
module tb_mandel_pixel_scheduler;

  localparam int TW = 4;
  localparam int TH = 2;
  localparam int X0  = -536870912;
  localparam int Y0  =  268435456;
  localparam int STP =  201326592;

  typedef struct {int x; int y; int c;} exp_t;

  logic clock = 1'b0;
  logic resetn;
  logic start;
  logic done;

  mandel_pixel_scheduler_if #(.COORD_W(32), .ITER_W(8)) bus ();

  mandel_pixel_scheduler #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clock(clock), .resetn(resetn), .start(start), .done(done), .bus(bus)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  int   pix, plots, ack_delay, req_cyc, lat;
  bit   use_tab, xfer_prev;
  logic [7:0]  cur_iter;
  logic [31:0] held_cr, held_ci;

  int iter_tab [8] = '{255, 8, 13, 0, 1, 2, 3, 4};
  int col_tab  [8] = '{0, 7, 5, 7, 1, 2, 3, 4};
  int col_dflt [8] = '{7, 1, 2, 3, 4, 5, 6, 7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine stub plus plot monitor, all decisions made on the falling edge.
  task automatic engine_stub();
    int ex, ey;
    exp_t e;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        lat = 0; xfer_prev = 0; req_cyc = 0;
        bus.eng_ack = 1'b0; bus.eng_valid = 1'b0;
      end else begin
        if (xfer_prev) begin
          xfer_prev = 0;
          lat = 3;
          check("req_drop", 32'(bus.eng_req), 32'd0);
        end
        bus.eng_valid = 1'b0;
        if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            bus.eng_valid = 1'b1;
            bus.eng_iter  = cur_iter;
          end
        end
        bus.eng_ack = 1'b0;
        if (bus.eng_req) begin
          if (req_cyc == 0) begin
            held_cr = bus.eng_cr;
            held_ci = bus.eng_ci;
          end else begin
            check("cr_hold", bus.eng_cr, held_cr);
            check("ci_hold", bus.eng_ci, held_ci);
          end
          if (req_cyc >= ack_delay) begin
            ex = pix % TW;
            ey = pix / TW;
            check("req_cr", bus.eng_cr, 32'(X0 + ex * STP));
            check("req_ci", bus.eng_ci, 32'(Y0 - ey * STP));
            if (ack_delay > 0) check("ack_wait", 32'(req_cyc), 32'(ack_delay));
            bus.eng_ack = 1'b1;
            xfer_prev   = 1;
            req_cyc     = 0;
            cur_iter    = use_tab ? 8'(iter_tab[pix]) : 8'(ex + 4 * ey);
            e.x = ex; e.y = ey; e.c = use_tab ? col_tab[pix] : col_dflt[pix];
            q.push_back(e);
            pix++;
          end else begin
            req_cyc++;
          end
        end
        if (bus.plot) begin
          plots++;
          if (q.size() == 0) begin
            check("plot_unexpected", 32'(bus.plot), 32'd0);
          end else begin
            e = q.pop_front();
            check("plot_x", 32'(bus.x), 32'(e.x));
            check("plot_y", 32'(bus.y), 32'(e.y));
            check("plot_colour", 32'(bus.colour), 32'(e.c));
          end
        end
      end
    end
  endtask

  task automatic run_frame(input string tag, input bit poke);
    int n;
    pix = 0; plots = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_req_first"}, 32'(bus.eng_req), 32'd1);
    if (poke) begin
      n = 0;
      while (!(bus.eng_req && pix >= 2) && n < 200) begin
        @(negedge clock); n++;
      end
      check({tag, "_poke_wait"}, 32'(bus.eng_req), 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 400) begin
      @(negedge clock); n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_plots"}, 32'(plots), 32'(TW * TH));
    check({tag, "_q_empty"}, 32'(q.size()), 32'd0);
    @(negedge clock);
    check({tag, "_done_hold"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},   32'(done),        32'd0);
    check({tag, "_req"},    32'(bus.eng_req), 32'd0);
    check({tag, "_plot"},   32'(bus.plot),    32'd0);
    check({tag, "_x"},      32'(bus.x),       32'd0);
    check({tag, "_y"},      32'(bus.y),       32'd0);
    check({tag, "_colour"}, 32'(bus.colour),  32'd0);
    check({tag, "_cr"},     bus.eng_cr,       32'(X0));
    check({tag, "_ci"},     bus.eng_ci,       32'(Y0));
  endtask

  initial begin
    int n;
    resetn = 1'b0; start = 1'b0;
    bus.eng_ack = 1'b0; bus.eng_valid = 1'b0; bus.eng_iter = '0;
    pix = 0; plots = 0; ack_delay = 0; req_cyc = 0; lat = 0;
    use_tab = 0; xfer_prev = 0; cur_iter = '0;
    fork
      engine_stub();
    join_none

    repeat (3) @(negedge clock);
    check_reset_outputs("rst");
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_done", 32'(done), 32'd0);
    check("idle_req", 32'(bus.eng_req), 32'd0);

    // basic frame, immediate ack, iter = x + 4*y
    run_frame("f1", 1'b0);

    // ack withheld 5 cycles per request
    ack_delay = 5;
    run_frame("f2", 1'b0);
    ack_delay = 0;

    // colour map edge values
    use_tab = 1;
    run_frame("f3", 1'b0);
    use_tab = 0;

    // start while busy is ignored; frame restarted from DONE is identical
    run_frame("f4", 1'b1);
    run_frame("f5", 1'b0);

    // reset during WAIT of pixel (2,1)
    pix = 0; plots = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (pix < 7 && n < 200) begin
      @(negedge clock); n++;
    end
    check("abort_reach", 32'(pix), 32'd7);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check_reset_outputs("abort");
    q.delete();
    @(negedge clock);
    check("abort_plot_hold", 32'(bus.plot), 32'd0);
    check("abort_plots", 32'(plots), 32'd6);
    resetn = 1'b1;
    @(negedge clock);
    check("abort_idle_req", 32'(bus.eng_req), 32'd0);
    run_frame("f6", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
